conv_lane_engine: RTL and testbench

// Next-generation on-chip 2-D convolution engine: LANES output channels computed in parallel, zero padding, STRIDE 1/2.

---
 rtl/conv_lane_engine.sv | 342 ++++++++++++++++++++++++++++++++++
 tb/tb_conv_lane_engine.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_lane_engine.sv
`default_nettype none
// ============================================================================
//  Module   : conv_lane_engine
//  Purpose  : 2-D convolution engine computing LANES output channels in
//             parallel with zero padding and stride 1 or 2. The input map and
//             the kernels live in on-chip SRAMs loaded through one addr/data
//             port. Each lane accumulates in a private register. Results leave
//             as shifted, saturated words through a valid/ready port.
//  Ports    : clk, arst_in           clock, asynchronous active-high reset
//             load_valid/ready/addr/data
//                                    SRAM loader, accepted only in IDLE.
//                                    addr[15]=1 selects kernel {inch,ky,kx,och},
//                                    addr[15]=0 selects input {inch,y,x}
//             start, busy, done      run control
//             out_valid/ready/data/x/y/ch
//                                    one result group (LANES channels) per beat
//  Revision : 1.0  initial release
// ============================================================================
module conv_lane_engine #(
    parameter int IO_DATA_WIDTH = 16,
    parameter int ACC_WIDTH     = 32,
    parameter int FM_WIDTH      = 16,
    parameter int FM_HEIGHT     = 16,
    parameter int IN_CH         = 2,
    parameter int OUT_CH        = 16,
    parameter int KERNEL_SIZE   = 3,
    parameter int LANES         = 4,
    parameter int STRIDE        = 1,
    parameter int OUTPUT_SHIFT  = 0,
    localparam int OW  = (FM_WIDTH + STRIDE - 1) / STRIDE,
    localparam int OH  = (FM_HEIGHT + STRIDE - 1) / STRIDE,
    localparam int OXW = (OW > 1) ? $clog2(OW) : 1,
    localparam int OYW = (OH > 1) ? $clog2(OH) : 1,
    localparam int OCW = (OUT_CH > 1) ? $clog2(OUT_CH) : 1
) (
    input  logic                             clk,
    input  logic                             arst_in,
    input  logic                             load_valid,
    output logic                             load_ready,
    input  logic [15:0]                      load_addr,
    input  logic [IO_DATA_WIDTH-1:0]         load_data,
    input  logic                             start,
    output logic                             busy,
    output logic                             done,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [LANES*IO_DATA_WIDTH-1:0]   out_data,
    output logic [OXW-1:0]                   out_x,
    output logic [OYW-1:0]                   out_y,
    output logic [OCW-1:0]                   out_ch
);

    localparam int W        = IO_DATA_WIDTH;
    localparam int K        = KERNEL_SIZE;
    localparam int PAD      = K / 2;
    localparam int NGRP     = OUT_CH / LANES;
    // Raw field widths of the load address (may be zero for size-1 fields).
    localparam int FXB      = $clog2(FM_WIDTH);
    localparam int FYB      = $clog2(FM_HEIGHT);
    localparam int ICB      = $clog2(IN_CH);
    localparam int KB       = $clog2(K);
    localparam int OCB      = $clog2(OUT_CH);
    // Register widths (at least one bit).
    localparam int ICW      = (IN_CH > 1) ? ICB : 1;
    localparam int KW       = (K > 1) ? KB : 1;
    localparam int GW       = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam int IN_DEPTH = IN_CH * FM_HEIGHT * FM_WIDTH;
    localparam int IAW      = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
    localparam int KB_DEPTH = IN_CH * K * K * NGRP;
    localparam int KAW      = (KB_DEPTH > 1) ? $clog2(KB_DEPTH) : 1;

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        ACC_WIDTH'((64'sd1 <<< (W - 1)) - 64'sd1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        ACC_WIDTH'(-(64'sd1 <<< (W - 1)));

    if ((OUT_CH % LANES) != 0) begin : g_bad_lanes
        $error("conv_lane_engine: OUT_CH must be a multiple of LANES");
    end
    if ((STRIDE != 1) && (STRIDE != 2)) begin : g_bad_stride
        $error("conv_lane_engine: STRIDE must be 1 or 2");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_FLUSH = 3'd2,
        S_OUT   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              state_q;
    logic [OYW-1:0]      oy_q;
    logic [OXW-1:0]      ox_q;
    logic [GW-1:0]       grp_q;
    logic [ICW-1:0]      ic_q;
    logic [KW-1:0]       ky_q;
    logic [KW-1:0]       kx_q;
    logic                drain_q;
    logic                busy_q;
    logic                done_q;
    logic                out_valid_q;
    logic [OXW-1:0]      out_x_q;
    logic [OYW-1:0]      out_y_q;
    logic [OCW-1:0]      out_ch_q;
    // Tap pipeline: stage 1 holds the SRAM read data of the tap issued last cycle.
    logic                v1_q;
    logic                first1_q;
    logic signed [W-1:0] in_rd_q;

    // ------------------------------------------------------------------
    // Load address decode
    // ------------------------------------------------------------------
    int                  w_la;
    int                  w_lx, w_ly, w_lic;
    int                  w_loch, w_lkx, w_lky, w_lkic;
    int                  w_k_bank;
    logic                w_in_we, w_k_we;
    logic [IAW-1:0]      w_in_waddr;
    logic [KAW-1:0]      w_k_waddr;

    always_comb begin
        w_la       = int'(load_addr[14:0]);
        w_lx       = w_la & ((1 << FXB) - 1);
        w_ly       = (w_la >> FXB) & ((1 << FYB) - 1);
        w_lic      = (w_la >> (FXB + FYB)) & ((1 << ICB) - 1);
        w_loch     = w_la & ((1 << OCB) - 1);
        w_lkx      = (w_la >> OCB) & ((1 << KB) - 1);
        w_lky      = (w_la >> (OCB + KB)) & ((1 << KB) - 1);
        w_lkic     = (w_la >> (OCB + 2 * KB)) & ((1 << ICB) - 1);
        w_in_we    = load_valid && load_ready && !load_addr[15] &&
                     (w_lx < FM_WIDTH) && (w_ly < FM_HEIGHT) && (w_lic < IN_CH);
        w_k_we     = load_valid && load_ready && load_addr[15] &&
                     (w_loch < OUT_CH) && (w_lkx < K) && (w_lky < K) && (w_lkic < IN_CH);
        w_in_waddr = IAW'((w_lic * FM_HEIGHT + w_ly) * FM_WIDTH + w_lx);
        // Bank holds every och with och % LANES == bank, ordered by group.
        w_k_bank   = w_loch % LANES;
        w_k_waddr  = KAW'(((w_lkic * K + w_lky) * K + w_lkx) * NGRP + w_loch / LANES);
    end

    // ------------------------------------------------------------------
    // Tap address generation
    // ------------------------------------------------------------------
    int                  w_iy, w_ix;
    logic                w_in_range;
    logic                w_issue;
    logic                w_first_tap;
    logic                w_last_tap;
    logic                w_last_grp;
    logic                w_load_out;
    logic [IAW-1:0]      w_in_raddr;
    logic [KAW-1:0]      w_k_raddr;

    always_comb begin
        w_iy        = int'(oy_q) * STRIDE + int'(ky_q) - PAD;
        w_ix        = int'(ox_q) * STRIDE + int'(kx_q) - PAD;
        w_in_range  = (w_iy >= 0) && (w_iy < FM_HEIGHT) && (w_ix >= 0) && (w_ix < FM_WIDTH);
        w_in_raddr  = IAW'((int'(ic_q) * FM_HEIGHT + w_iy) * FM_WIDTH + w_ix);
        w_k_raddr   = KAW'(((int'(ic_q) * K + int'(ky_q)) * K + int'(kx_q)) * NGRP + int'(grp_q));
        w_issue     = (state_q == S_RUN);
        w_first_tap = (ic_q == '0) && (ky_q == '0) && (kx_q == '0);
        w_last_tap  = (ic_q == ICW'(IN_CH - 1)) && (ky_q == KW'(K - 1)) && (kx_q == KW'(K - 1));
        w_last_grp  = (grp_q == GW'(NGRP - 1)) && (ox_q == OXW'(OW - 1)) && (oy_q == OYW'(OH - 1));
        // Second FLUSH cycle: the last product has entered the accumulators.
        w_load_out  = (state_q == S_FLUSH) && drain_q;
    end

    // Input SRAM; out-of-range taps skip the read and feed a zero operand.
    logic signed [W-1:0] in_mem [IN_DEPTH];

    always_ff @(posedge clk) begin
        if (w_in_we) begin
            in_mem[w_in_waddr] <= load_data;
        end
        if (w_issue && w_in_range) begin
            in_rd_q <= in_mem[w_in_raddr];
        end else begin
            in_rd_q <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            state_q     <= S_IDLE;
            oy_q        <= '0;
            ox_q        <= '0;
            grp_q       <= '0;
            ic_q        <= '0;
            ky_q        <= '0;
            kx_q        <= '0;
            drain_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_ch_q    <= '0;
            v1_q        <= 1'b0;
            first1_q    <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            v1_q     <= w_issue;
            first1_q <= w_issue && w_first_tap;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_RUN;
                        busy_q  <= 1'b1;
                        oy_q    <= '0;
                        ox_q    <= '0;
                        grp_q   <= '0;
                        ic_q    <= '0;
                        ky_q    <= '0;
                        kx_q    <= '0;
                    end
                end
                S_RUN: begin
                    if (w_last_tap) begin
                        state_q <= S_FLUSH;
                        drain_q <= 1'b0;
                        ic_q    <= '0;
                        ky_q    <= '0;
                        kx_q    <= '0;
                    end else if (kx_q == KW'(K - 1)) begin
                        kx_q <= '0;
                        if (ky_q == KW'(K - 1)) begin
                            ky_q <= '0;
                            ic_q <= ic_q + 1'b1;
                        end else begin
                            ky_q <= ky_q + 1'b1;
                        end
                    end else begin
                        kx_q <= kx_q + 1'b1;
                    end
                end
                S_FLUSH: begin
                    drain_q <= 1'b1;
                    if (drain_q) begin
                        state_q     <= S_OUT;
                        out_valid_q <= 1'b1;
                        out_x_q     <= ox_q;
                        out_y_q     <= oy_q;
                        out_ch_q    <= OCW'(int'(grp_q) * LANES);
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (w_last_grp) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= S_RUN;
                            if (grp_q == GW'(NGRP - 1)) begin
                                grp_q <= '0;
                                if (ox_q == OXW'(OW - 1)) begin
                                    ox_q <= '0;
                                    oy_q <= oy_q + 1'b1;
                                end else begin
                                    ox_q <= ox_q + 1'b1;
                                end
                            end else begin
                                grp_q <= grp_q + 1'b1;
                            end
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Lanes: kernel bank, MAC, output saturation
    // ------------------------------------------------------------------
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic signed [W-1:0]         k_mem [KB_DEPTH];
        logic signed [W-1:0]         k_rd_q;
        logic signed [2*W-1:0]       w_mul;
        logic signed [ACC_WIDTH-1:0] w_prod;
        logic signed [ACC_WIDTH-1:0] w_shift;
        logic [W-1:0]                w_sat;
        logic signed [ACC_WIDTH-1:0] acc_q;
        logic [W-1:0]                out_q;

        always_ff @(posedge clk) begin
            if (w_k_we && (w_k_bank == l)) begin
                k_mem[w_k_waddr] <= load_data;
            end
            k_rd_q <= k_mem[w_k_raddr];
        end

        always_comb begin
            w_mul   = in_rd_q * k_rd_q;
            w_prod  = ACC_WIDTH'(w_mul);
            w_shift = acc_q >>> OUTPUT_SHIFT;
            if (w_shift > SAT_MAX) begin
                w_sat = SAT_MAX[W-1:0];
            end else if (w_shift < SAT_MIN) begin
                w_sat = SAT_MIN[W-1:0];
            end else begin
                w_sat = w_shift[W-1:0];
            end
        end

        // Accumulator wraps on overflow; the first tap of a group overwrites it.
        always_ff @(posedge clk or posedge arst_in) begin
            if (arst_in) begin
                acc_q <= '0;
                out_q <= '0;
            end else begin
                if (v1_q) begin
                    acc_q <= first1_q ? w_prod : (acc_q + w_prod);
                end
                if (w_load_out) begin
                    out_q <= w_sat;
                end
            end
        end

        assign out_data[l*W +: W] = out_q;
    end

    assign load_ready = (state_q == S_IDLE);
    assign busy       = busy_q;
    assign done       = done_q;
    assign out_valid  = out_valid_q;
    assign out_x      = out_x_q;
    assign out_y      = out_y_q;
    assign out_ch     = out_ch_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_lane_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_conv_lane_engine
//  Purpose  : Scoreboard bench for conv_lane_engine. Two engines share the
//             load bus and start: A (stride 1, shift 0) and B (stride 2,
//             shift 4). A reference model computes every expected result
//             group at start time; per-engine monitors pop and compare.
//  Revision : 1.0  initial release
// ============================================================================
module tb_conv_lane_engine;

    localparam int W   = 16;
    localparam int FW  = 16;
    localparam int FH  = 16;
    localparam int IC  = 2;
    localparam int OC  = 16;
    localparam int K   = 3;
    localparam int L   = 4;
    localparam int N   = IC * K * K;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_valid;
    logic [15:0] load_addr;
    logic [15:0] load_data;
    logic        start;

    logic        a_load_ready, a_busy, a_done, a_out_valid, a_out_ready;
    logic [63:0] a_out_data;
    logic [3:0]  a_out_x, a_out_y, a_out_ch;
    logic        b_load_ready, b_busy, b_done, b_out_valid, b_out_ready;
    logic [63:0] b_out_data;
    logic [2:0]  b_out_x, b_out_y;
    logic [3:0]  b_out_ch;

    always #5 clk = ~clk;

    conv_lane_engine u_dut_a (
        .clk(clk), .arst_in(rst),
        .load_valid(load_valid), .load_ready(a_load_ready),
        .load_addr(load_addr), .load_data(load_data),
        .start(start), .busy(a_busy), .done(a_done),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_x(a_out_x), .out_y(a_out_y), .out_ch(a_out_ch)
    );

    conv_lane_engine #(.STRIDE(2), .OUTPUT_SHIFT(4)) u_dut_b (
        .clk(clk), .arst_in(rst),
        .load_valid(load_valid), .load_ready(b_load_ready),
        .load_addr(load_addr), .load_data(load_data),
        .start(start), .busy(b_busy), .done(b_done),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_x(b_out_x), .out_y(b_out_y), .out_ch(b_out_ch)
    );

    typedef struct {
        int          x;
        int          y;
        int          ch;
        logic [63:0] data;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    int in_m [IC][FH][FW];
    int k_m  [OC][IC][K][K];

    int vectors     = 0;
    int miscompares = 0;
    int a_dn = 0, b_dn = 0;
    int a_acc_cnt = 0;
    int a_hold_cnt = 0;
    bit a_hold_req = 0;
    bit bp_rand = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [15:0] model_lane(int stride, int shift, int oy, int ox, int och);
        int acc;
        int sh;
        int iy, ix;
        acc = 0;
        for (int ic = 0; ic < IC; ic++)
            for (int ky = 0; ky < K; ky++)
                for (int kx = 0; kx < K; kx++) begin
                    iy = oy * stride + ky - K / 2;
                    ix = ox * stride + kx - K / 2;
                    if (iy >= 0 && iy < FH && ix >= 0 && ix < FW)
                        acc += in_m[ic][iy][ix] * k_m[och][ic][ky][kx];
                end
        sh = acc >>> shift;
        if (sh > 32767) return 16'h7FFF;
        if (sh < -32768) return 16'h8000;
        return sh[15:0];
    endfunction

    task automatic push_expected(input int stride, input int shift, input bit to_a);
        exp_t e;
        int oh, ow;
        oh = (FH + stride - 1) / stride;
        ow = (FW + stride - 1) / stride;
        for (int oy = 0; oy < oh; oy++)
            for (int ox = 0; ox < ow; ox++)
                for (int g = 0; g < OC / L; g++) begin
                    e.x  = ox;
                    e.y  = oy;
                    e.ch = g * L;
                    for (int l = 0; l < L; l++)
                        e.data[l*16 +: 16] = model_lane(stride, shift, oy, ox, g * L + l);
                    if (to_a) qa.push_back(e);
                    else      qb.push_back(e);
                end
    endtask

    // ---------------- load helpers ----------------
    task automatic drive_load(input logic [15:0] addr, input logic [15:0] data);
        @(negedge clk);
        load_valid = 1'b1;
        load_addr  = addr;
        load_data  = data;
        @(posedge clk);
        #1 load_valid = 1'b0;
    endtask

    task automatic load_in(input int ic, input int y, input int x, input int v);
        logic signed [15:0] t;
        t = v[15:0];
        in_m[ic][y][x] = t;
        drive_load(16'((ic << 8) | (y << 4) | x), t);
    endtask

    task automatic load_k(input int och, input int ic, input int ky, input int kx, input int v);
        logic signed [15:0] t;
        t = v[15:0];
        k_m[och][ic][ky][kx] = t;
        drive_load(16'(32'h8000 | (ic << 8) | (ky << 6) | (kx << 4) | och), t);
    endtask

    // mode 0: small random, 1: all ones, 2: saturation mix
    task automatic fill(input int mode);
        int v;
        for (int ic = 0; ic < IC; ic++)
            for (int y = 0; y < FH; y++)
                for (int x = 0; x < FW; x++) begin
                    case (mode)
                        0: v = int'($urandom_range(15, 0)) - 8;
                        1: v = 1;
                        default: v = 32767;
                    endcase
                    load_in(ic, y, x, v);
                end
        for (int och = 0; och < OC; och++)
            for (int ic = 0; ic < IC; ic++)
                for (int ky = 0; ky < K; ky++)
                    for (int kx = 0; kx < K; kx++) begin
                        case (mode)
                            0: v = int'($urandom_range(15, 0)) - 8;
                            1: v = 1;
                            default: begin
                                case (och % 4)
                                    0: v = 32'h7FFF;
                                    1: v = -32767;
                                    2: v = 0;
                                    default: v = (ic == 0 && ky == 1 && kx == 1) ? 1 : 0;
                                endcase
                            end
                        endcase
                        load_k(och, ic, ky, kx, v);
                    end
    endtask

    // ---------------- backpressure drivers ----------------
    initial begin
        a_out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (a_hold_req && a_acc_cnt == 2 && a_out_valid && a_hold_cnt < 10) begin
                a_out_ready = 1'b0;
                a_hold_cnt++;
            end else begin
                a_out_ready = bp_rand ? ($urandom_range(3, 0) != 0) : 1'b1;
            end
        end
    end

    initial begin
        b_out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            b_out_ready = bp_rand ? ($urandom_range(2, 0) != 0) : 1'b1;
        end
    end

    // ---------------- monitors ----------------
    bit          a_hold = 0, b_hold = 0;
    logic [63:0] a_pd, b_pd;
    int          a_px, a_py, a_pc, b_px, b_py, b_pc;

    always @(negedge clk) begin
        if (rst) begin
            a_hold = 0;
        end else begin
            if (a_hold) begin
                vectors++;
                if (!a_out_valid || a_out_data != a_pd || int'(a_out_x) != a_px ||
                    int'(a_out_y) != a_py || int'(a_out_ch) != a_pc) begin
                    miscompares++;
                    $display("FAIL a_stall_hold: got v=%0b x=%0d y=%0d ch=%0d d=%h required v=1 x=%0d y=%0d ch=%0d d=%h",
                             a_out_valid, a_out_x, a_out_y, a_out_ch, a_out_data, a_px, a_py, a_pc, a_pd);
                end
            end
            if (a_out_valid && a_out_ready) begin
                vectors++;
                a_acc_cnt++;
                if (qa.size() == 0) begin
                    miscompares++;
                    $display("FAIL a_unexpected: got x=%0d y=%0d ch=%0d required no output", a_out_x, a_out_y, a_out_ch);
                end else begin
                    exp_t e;
                    e = qa.pop_front();
                    if (int'(a_out_x) != e.x || int'(a_out_y) != e.y || int'(a_out_ch) != e.ch || a_out_data != e.data) begin
                        miscompares++;
                        $display("FAIL a_group: got x=%0d y=%0d ch=%0d d=%h required x=%0d y=%0d ch=%0d d=%h",
                                 a_out_x, a_out_y, a_out_ch, a_out_data, e.x, e.y, e.ch, e.data);
                    end
                end
            end
            if (a_done) begin
                a_dn++;
                chk("a_busy_at_done", a_busy, 0);
            end
            a_hold = a_out_valid && !a_out_ready;
            a_pd = a_out_data; a_px = a_out_x; a_py = a_out_y; a_pc = a_out_ch;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            b_hold = 0;
        end else begin
            if (b_hold) begin
                vectors++;
                if (!b_out_valid || b_out_data != b_pd || int'(b_out_x) != b_px ||
                    int'(b_out_y) != b_py || int'(b_out_ch) != b_pc) begin
                    miscompares++;
                    $display("FAIL b_stall_hold: got v=%0b x=%0d y=%0d ch=%0d d=%h required v=1 x=%0d y=%0d ch=%0d d=%h",
                             b_out_valid, b_out_x, b_out_y, b_out_ch, b_out_data, b_px, b_py, b_pc, b_pd);
                end
            end
            if (b_out_valid && b_out_ready) begin
                vectors++;
                if (qb.size() == 0) begin
                    miscompares++;
                    $display("FAIL b_unexpected: got x=%0d y=%0d ch=%0d required no output", b_out_x, b_out_y, b_out_ch);
                end else begin
                    exp_t e;
                    e = qb.pop_front();
                    if (int'(b_out_x) != e.x || int'(b_out_y) != e.y || int'(b_out_ch) != e.ch || b_out_data != e.data) begin
                        miscompares++;
                        $display("FAIL b_group: got x=%0d y=%0d ch=%0d d=%h required x=%0d y=%0d ch=%0d d=%h",
                                 b_out_x, b_out_y, b_out_ch, b_out_data, e.x, e.y, e.ch, e.data);
                    end
                end
            end
            if (b_done) begin
                b_dn++;
                chk("b_busy_at_done", b_busy, 0);
            end
            b_hold = b_out_valid && !b_out_ready;
            b_pd = b_out_data; b_px = b_out_x; b_py = b_out_y; b_pc = b_out_ch;
        end
    end

    // ---------------- run control ----------------
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_a_load_ready"}, a_load_ready, 1);
        chk({tag, "_a_busy"}, a_busy, 0);
        chk({tag, "_a_out_valid"}, a_out_valid, 0);
        chk({tag, "_b_load_ready"}, b_load_ready, 1);
        chk({tag, "_b_busy"}, b_busy, 0);
        chk({tag, "_b_out_valid"}, b_out_valid, 0);
    endtask

    task automatic full_run(input bit garbage);
        int cyc;
        int c;
        a_dn = 0;
        b_dn = 0;
        a_acc_cnt = 0;
        a_hold_cnt = 0;
        push_expected(1, 0, 1'b1);
        push_expected(2, 4, 1'b0);
        pulse_start();
        chk("busy_after_start", a_busy & b_busy, 1);
        cyc = 0;
        while (!a_out_valid && cyc < 100) begin
            @(posedge clk);
            #1 cyc++;
        end
        chk("a_first_latency", cyc, N + 2);
        chk("b_first_valid", b_out_valid, 1);
        if (garbage) begin
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                chk("load_ready_in_run", a_load_ready | b_load_ready, 0);
                load_valid = 1'b1;
                load_addr  = 16'($urandom);
                load_data  = 16'($urandom);
                start      = (i == 5);
                @(posedge clk);
                #1 load_valid = 1'b0;
                start = 1'b0;
            end
        end
        c = 0;
        while (!(a_dn > 0 && b_dn > 0) && c < 40000) begin
            @(posedge clk);
            c++;
        end
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("a_done_pulses", a_dn, 1);
        chk("b_done_pulses", b_dn, 1);
        chk("a_queue_left", qa.size(), 0);
        chk("b_queue_left", qb.size(), 0);
        check_idle_outputs("post_run");
        qa.delete();
        qb.delete();
    endtask

    initial begin
        rst        = 1'b1;
        load_valid = 1'b0;
        load_addr  = '0;
        load_data  = '0;
        start      = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        chk("reset_a_done", a_done, 0);
        chk("reset_a_out_data", a_out_data, 0);
        chk("reset_a_out_xy", {a_out_x, a_out_y, a_out_ch}, 0);
        chk("reset_b_out_data", b_out_data, 0);
        rst = 1'b0;

        // Padding pattern, first aborted by a reset mid-RUN, then re-run
        fill(1);
        pulse_start();
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("pre_abort_busy", a_busy, 1);
        rst = 1'b1;
        #1;
        check_idle_outputs("abort");
        @(negedge clk);
        rst = 1'b0;
        full_run(1'b0);

        // Random data, random backpressure, long stall on the third group,
        // ignored loads and start while running
        fill(0);
        bp_rand    = 1'b1;
        a_hold_req = 1'b1;
        full_run(1'b1);
        chk("a_hold_cycles", a_hold_cnt, 10);
        a_hold_req = 1'b0;
        bp_rand    = 1'b0;

        // Saturation mix
        fill(2);
        full_run(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
